keyboard_fifo: RTL and testbench
================================

Name: keyboard_fifo

Overview:
Buffers PS/2 scancode bytes from ps2_rx and decodes the 0xE0 (extended) and 0xF0 (release) prefixes into key events. Stores the events in a FIFO that the CPU reads through the keyboard window of memory_controller. Sits between ps2_rx (valid/scancode) and memory_controller's keyboard_* port group, all on clk_100mhz.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..256.

Ports:
clk_in  input  1  system clock (clk_100mhz)
rst_in  input  1  reset; one clock; reset is asynchronous and active-low
valid_in  input  1  one-cycle strobe: scancode_in holds a new byte
scancode_in  input  8  raw PS/2 byte
addr_in  input  32  CPU byte address; only addr_in[3:2] decoded
data_in  input  32  CPU write data
write_enable_in  input  4  byte write enables; a write occurs only when bit 0 is set
data_out  output  32  registered read data
not_empty_out  output  1  FIFO holds at least one event

Behaviour:
- Reset (rst_in=0, async):
  - FIFO empty; read/write pointers = 0; count = 0.
  - overflow = 0; prefix FSM = IDLE.
  - data_out = 0; not_empty_out = 0.
- Entry format, 10 bits: {ext, rel, code[7:0]}.
- Prefix FSM, advanced only on valid_in:
  - IDLE: byte E0 -> GOT_E0; F0 -> GOT_F0; any other byte -> push {0,0,b}, stay IDLE.
  - GOT_E0: E0 -> GOT_E0; F0 -> GOT_E0F0; other -> push {1,0,b}, go IDLE.
  - GOT_F0: F0 -> GOT_F0; E0 -> GOT_E0 (anomaly, restart); other -> push {0,1,b}, go IDLE.
  - GOT_E0F0: E0 -> GOT_E0; F0 -> GOT_E0F0; other -> push {1,1,b}, go IDLE.
  - A push occurs in the same cycle as the valid_in that completes the event.
- Register map (word index addr_in[3:2]):
  - 0 DATA, read: {valid, 21'b0, ext, rel, code}. valid = FIFO non-empty. Low bits show the head entry, or 0 when empty. Write ignored.
  - 1 STATUS, read: {16'b0, count[7:0] zero-extended, 5'b0, overflow, full, empty}. Write ignored.
  - 2 CTRL, write: bit0 pop, bit1 clear FIFO + FSM, bit2 clear overflow. Reads 0.
  - 3 reserved: reads 0, write ignored.
- Read latency: data_out is registered, 1 cycle. It reflects state at the clock edge where addr_in was sampled, before that edge's updates. Reads have no side effects.
- Pop:
  - Takes effect at the edge of the CTRL write; the next DATA read shows the new head.
  - Pop on empty: ignored, no error.
- Push while full: entry dropped, overflow set (sticky). Count and pointers unchanged.
- Simultaneous push + pop:
  - Non-empty: both occur, count unchanged (including when full; no overflow).
  - Empty: pop ignored, push occurs.
- Clear bit1 in the same cycle as a push or pop: clear wins, incoming entry discarded, FSM -> IDLE. Clear does not touch overflow unless bit2 is also set.
- Overflow set and clear in the same cycle: set wins.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. count has log2(DEPTH)+1 bits, range 0..DEPTH.
- full = (count == DEPTH); empty = (count == 0).
- not_empty_out is combinational from count.
- Storage: distributed/register array; no read-during-write hazard is exposed because head data is registered via data_out.

Test Plan:
- Reset, then read STATUS -> data_out = 0x00000001 one cycle later; DATA reads 0x00000000; not_empty_out = 0.
- Bytes 1C; F0 1C; E0 75; E0 F0 75 -> four entries; DATA reads 0x8000001C, 0x8000011C, 0x80000275, 0x80000375, each after a CTRL pop (write 0x1 to word 2). The final pop leaves STATUS = 0x00000001.
- Push 17 codes with DEPTH=16 -> STATUS = 0x00001006 (count 16, overflow, full). The 17th byte is lost; the head is still the first byte. Then write CTRL 0x4 -> STATUS = 0x00001002.
- FIFO full; valid_in and CTRL pop in the same cycle -> count stays 16, overflow stays 0, pointers wrap correctly. All 16 subsequent pops return bytes in order.
- Byte F0, then CTRL 0x2, then byte 1C -> entry is {0,0,1C}: FSM cleared, so no release flag. A clear coincident with valid_in leaves count 0.
- Assert rst_in=0 mid-sequence (after E0, with 3 entries queued) -> outputs go 0 immediately without a clock edge. After release, byte 75 -> DATA 0x80000075.

Source files
------------

// File: rtl/keyboard_fifo.sv
// keyboard_fifo: decodes PS/2 E0/F0 prefixes into {ext, rel, code} key
// events, queues them, and exposes the queue through a small register window
// (DATA / STATUS / CTRL) for the CPU.
module keyboard_fifo #(
   parameter int DEPTH = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        valid_in,
   input  logic [7:0]  scancode_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] data_in,
   input  logic [3:0]  write_enable_in,
   output logic [31:0] data_out,
   output logic        not_empty_out
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} pfx_t;

   pfx_t          state;
   logic [9:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;

   logic          full, empty;
   logic          is_prefix, push_req, push_ok, pop_ok, ovf_set;
   logic          ctrl_wr, clr, pop_req, ovf_clr;
   logic [9:0]    entry;
   logic [31:0]   rd_data;
   logic          unused_ok;

   assign full          = (count == CW'(DEPTH));
   assign empty         = (count == '0);
   assign not_empty_out = ~empty;

   // CTRL register decode; only byte lane 0 carries the command bits
   assign ctrl_wr = write_enable_in[0] && (addr_in[3:2] == 2'd2);
   assign pop_req = ctrl_wr && data_in[0];
   assign clr     = ctrl_wr && data_in[1];
   assign ovf_clr = ctrl_wr && data_in[2];

   // Any non-prefix byte completes an event, flagged by the prefixes seen so far
   assign is_prefix = (scancode_in == 8'hE0) || (scancode_in == 8'hF0);
   assign push_req  = valid_in && !is_prefix;
   assign entry     = {(state == GOT_E0) || (state == GOT_E0F0),
                       (state == GOT_F0) || (state == GOT_E0F0),
                       scancode_in};

   // A pop frees a slot in the same cycle, so push+pop on a full FIFO succeeds
   assign pop_ok  = pop_req && !empty && !clr;
   assign push_ok = push_req && (!full || pop_ok) && !clr;
   assign ovf_set = push_req && full && !pop_ok && !clr;

   assign unused_ok = ^{addr_in[31:4], addr_in[1:0], data_in[31:3],
                        write_enable_in[3:1]};

   // Prefix decoder: tracks E0/F0 bytes preceding the code byte
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state <= IDLE;
      end else if (clr) begin
         state <= IDLE;
      end else if (valid_in) begin
         if (scancode_in == 8'hE0) begin
            state <= GOT_E0;
         end else if (scancode_in == 8'hF0) begin
            case (state)
               IDLE:    state <= GOT_F0;
               GOT_E0:  state <= GOT_E0F0;
               default: state <= state;
            endcase
         end else begin
            state <= IDLE;
         end
      end
   end

   // Storage array; head is only observed through the registered data_out
   always_ff @(posedge clk_in) begin
      if (push_ok) mem[wr_ptr] <= entry;
   end

   // Pointers and occupancy; clear wins over any push or pop
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow flag; a new drop beats a simultaneous clear
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)      overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
   end

   // Register window read mux, sampled against pre-edge state
   always_comb begin
      rd_data = '0;
      case (addr_in[3:2])
         2'd0:    rd_data = {~empty, 21'b0, empty ? 10'd0 : mem[rd_ptr]};
         2'd1:    rd_data = {16'b0, 8'(count), 5'b0, overflow, full, empty};
         default: rd_data = '0;
      endcase
   end

   // Registered read data, one cycle of latency
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) data_out <= '0;
      else         data_out <= rd_data;
   end

endmodule

// File: tb/tb_keyboard_fifo.sv
// tb_keyboard_fifo: directed plan steps followed by a random phase, all
// checked against a queue-based model of the key-event FIFO.
module tb_keyboard_fifo;

   localparam int DEPTH = 16;

   logic        clk, rst_n, valid;
   logic [7:0]  code;
   logic [31:0] addr, wdata;
   logic [3:0]  we;
   logic [31:0] data_out;
   logic        not_empty;

   keyboard_fifo #(.DEPTH(DEPTH)) dut (
      .clk_in          (clk),
      .rst_in          (rst_n),
      .valid_in        (valid),
      .scancode_in     (code),
      .addr_in         (addr),
      .data_in         (wdata),
      .write_enable_in (we),
      .data_out        (data_out),
      .not_empty_out   (not_empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: event queue, sticky overflow, pending prefix flags
   logic [9:0] q[$];
   logic       m_ovf, m_ext, m_rel;
   int         total, fails;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input int word);
      logic [31:0] r;
      r = '0;
      if (word == 0 && q.size() > 0)
         r = {1'b1, 21'b0, q[0]};
      else if (word == 1)
         r = {16'b0, 8'(q.size()), 5'b0, m_ovf, q.size() == DEPTH, q.size() == 0};
      return r;
   endfunction

   task automatic model_reset();
      q.delete();
      m_ovf = 1'b0;
      m_ext = 1'b0;
      m_rel = 1'b0;
   endtask

   // One clock: drive inputs, advance the model, then check outputs
   task automatic cyc(input logic v, input logic [7:0] b, input int word,
                      input logic [3:0] w, input logic [31:0] d, input string tag);
      logic [31:0] exp;
      logic        wr, c_pop, c_clr, c_oc, do_push, set;
      logic [9:0]  ent;
      valid = v; code = b; addr = 32'(word) << 2; we = w; wdata = d;
      exp = model_read(word);
      wr = w[0] && (word == 2);
      c_pop = wr && d[0]; c_clr = wr && d[1]; c_oc = wr && d[2];
      do_push = 1'b0; set = 1'b0; ent = '0;
      if (v) begin
         if (b == 8'hE0) begin
            m_ext = 1'b1; m_rel = 1'b0;
         end else if (b == 8'hF0) begin
            m_rel = 1'b1;
         end else begin
            ent = {m_ext, m_rel, b}; do_push = 1'b1;
            m_ext = 1'b0; m_rel = 1'b0;
         end
      end
      if (c_clr) begin
         q.delete(); m_ext = 1'b0; m_rel = 1'b0;
      end else begin
         if (c_pop && q.size() > 0) void'(q.pop_front());
         if (do_push) begin
            if (q.size() < DEPTH) q.push_back(ent);
            else set = 1'b1;
         end
      end
      if (set) m_ovf = 1'b1;
      else if (c_oc) m_ovf = 1'b0;
      @(posedge clk);
      #1;
      valid = 1'b0; we = 4'h0;
      chk({tag, ".rd"}, data_out, exp);
      chk({tag, ".ne"}, 32'(not_empty), 32'(q.size() != 0));
   endtask

   task automatic send(input logic [7:0] b);
      cyc(1'b1, b, 3, 4'h0, 32'h0, "send");
   endtask

   task automatic rd(input int word, input string tag);
      cyc(1'b0, 8'h00, word, 4'h0, 32'h0, tag);
   endtask

   task automatic ctl(input logic [31:0] d, input string tag);
      cyc(1'b0, 8'h00, 2, 4'h1, d, tag);
   endtask

   initial begin
      total = 0; fails = 0;
      rst_n = 1'b0; valid = 1'b0; code = '0; addr = '0; wdata = '0; we = '0;
      model_reset();
      #12;
      chk("rst.data", data_out, 32'h0);
      chk("rst.ne", 32'(not_empty), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Reset state through the register window
      rd(1, "status0");
      rd(0, "data0");
      rd(0, "data0b");
      chk("status0.lit", data_out, 32'h0);

      // Four prefix combinations
      send(8'h1C);
      send(8'hF0); send(8'h1C);
      send(8'hE0); send(8'h75);
      send(8'hE0); send(8'hF0); send(8'h75);
      rd(0, "ev0"); rd(0, "ev0b"); chk("ev0.lit", data_out, 32'h8000001C); ctl(32'h1, "pop0");
      rd(0, "ev1"); rd(0, "ev1b"); chk("ev1.lit", data_out, 32'h8000011C); ctl(32'h1, "pop1");
      rd(0, "ev2"); rd(0, "ev2b"); chk("ev2.lit", data_out, 32'h80000275); ctl(32'h1, "pop2");
      rd(0, "ev3"); rd(0, "ev3b"); chk("ev3.lit", data_out, 32'h80000375); ctl(32'h1, "pop3");
      rd(1, "st_e"); rd(1, "st_eb"); chk("st_e.lit", data_out, 32'h00000001);
      ctl(32'h1, "pop_empty");

      // Overflow: 17 pushes into 16 slots
      for (int i = 1; i <= DEPTH + 1; i++) send(8'(i));
      rd(1, "ovf"); rd(1, "ovfb"); chk("ovf.lit", data_out, 32'h00001006);
      rd(0, "ovf_head"); rd(0, "ovf_headb"); chk("ovf_head.lit", data_out, 32'h80000001);
      ctl(32'h4, "ovf_clr");
      rd(1, "ovf_c"); rd(1, "ovf_cb"); chk("ovf_c.lit", data_out, 32'h00001002);

      // Full with simultaneous push and pop, then drain in order
      cyc(1'b1, 8'h55, 2, 4'h1, 32'h1, "full_pp");
      rd(1, "full_st"); rd(1, "full_stb"); chk("full_st.lit", data_out, 32'h00001002);
      for (int i = 0; i < DEPTH; i++) begin
         rd(0, "drain"); rd(0, "drain_b");
         ctl(32'h1, "drain_pop");
      end
      rd(1, "drained"); rd(1, "drainedb"); chk("drained.lit", data_out, 32'h00000001);

      // Clear resets the prefix decoder
      send(8'hF0);
      ctl(32'h2, "clr");
      send(8'h1C);
      rd(0, "clr_ev"); rd(0, "clr_evb"); chk("clr_ev.lit", data_out, 32'h8000001C);
      cyc(1'b1, 8'h22, 2, 4'h1, 32'h2, "clr_push");
      rd(1, "clr_st"); rd(1, "clr_stb"); chk("clr_st.lit", data_out, 32'h00000001);

      // Asynchronous reset mid-sequence
      send(8'h11); send(8'h12); send(8'h13);
      send(8'hE0);
      rd(0, "pre_rst");
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst.data", data_out, 32'h0);
      chk("arst.ne", 32'(not_empty), 32'h0);
      #1 rst_n = 1'b1;
      send(8'h75);
      rd(0, "post_rst"); rd(0, "post_rstb"); chk("post_rst.lit", data_out, 32'h80000075);
      ctl(32'h1, "post_pop");

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic        v;
         logic [7:0]  b;
         logic [31:0] d;
         int          sel, word;
         v = ($urandom_range(0, 3) != 0);
         sel = $urandom_range(0, 9);
         b = (sel < 2) ? 8'hE0 : (sel < 4) ? 8'hF0 : 8'($urandom);
         word = $urandom_range(0, 3);
         d = {29'($urandom), ($urandom_range(0, 15) == 0), 1'b0, 1'($urandom)};
         d[1] = ($urandom_range(0, 40) == 0);
         cyc(v, b, word, 4'($urandom), d, "rand");
      end

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
